// File: rtl/dmem_pkg.sv
// dmem_pkg: shared constants, types and block arithmetic for the 7x16 data memory
package dmem_pkg;
  localparam int NUM_BLOCKS  = 7;
  localparam int BLOCK_WORDS = 16;
  localparam int ADDR_W      = 7;
  localparam int DATA_W      = 16;
  typedef logic [2:0] blk_t;
  typedef enum logic [1:0] {IDLE, WRITE, FIN} state_t;
  function automatic blk_t next_block_mod7(input blk_t b);
    return (b == blk_t'(NUM_BLOCKS - 1)) ? '0 : blk_t'(b + 3'd1);
  endfunction
endpackage

// File: rtl/dmem_wr_addr_gen_if.sv
// dmem_wr_addr_gen_if: stream input, dmem write port and frame status of the write generator
interface dmem_wr_addr_gen_if;
  import dmem_pkg::*;
  logic              start;
  blk_t              start_block;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              dmem_we;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic              busy;
  logic              block_done;
  blk_t              blk_idx;
  logic              frame_done;
  modport slave (
    input  start, start_block, in_valid, in_data,
    output in_ready, dmem_we, dmem_addr, dmem_wdata, busy, block_done, blk_idx, frame_done
  );
  modport master (
    output start, start_block, in_valid, in_data,
    input  in_ready, dmem_we, dmem_addr, dmem_wdata, busy, block_done, blk_idx, frame_done
  );
endinterface

// File: rtl/dmem_blk_ctr.sv
// dmem_blk_ctr: mod-7 block counter with load (7 folds to 0) and increment
module dmem_blk_ctr
  import dmem_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  input  logic inc_i,
  input  blk_t load_val_i,
  output blk_t blk_o
);
  blk_t blk_q, blk_d;
  // load has priority; an out-of-range start block restarts at block 0
  always_comb blk_d = load_i ? ((load_val_i == blk_t'(NUM_BLOCKS)) ? '0 : load_val_i)
                    : inc_i  ? next_block_mod7(blk_q) : blk_q;
  // block register
  always_ff @(posedge clk)
    if (rst) blk_q <= '0;
    else blk_q <= blk_d;
  assign blk_o = blk_q;
endmodule

// File: rtl/dmem_wr_addr_gen.sv
// dmem_wr_addr_gen: fills dmem block by block from a valid/ready stream, one frame = 112 words
module dmem_wr_addr_gen
  import dmem_pkg::*;
(
  input logic clk,
  input logic rst,
  dmem_wr_addr_gen_if.slave bus
);
  state_t            state_q, state_d;
  logic [3:0]        off_q, off_d;
  blk_t              bw_q, bw_d;
  blk_t              cur_blk;
  logic              ld, in_ready, acc, blk_end;
  logic              we_q, bd_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  blk_t              bidx_q;
  // handshake, offset and block bookkeeping; WRITE stays one extra cycle after the
  // last acceptance so that FIN (frame_done) lands the cycle after the last write
  always_comb begin
    ld       = (state_q == IDLE) && bus.start;
    in_ready = !rst && (state_q == WRITE) && (bw_q != blk_t'(NUM_BLOCKS));
    acc      = bus.in_valid && in_ready;
    blk_end  = acc && (off_q == 4'(BLOCK_WORDS - 1));
    off_d    = ld ? '0 : acc ? off_q + 4'd1 : off_q;
    bw_d     = ld ? '0 : blk_end ? bw_q + 3'd1 : bw_q;
    state_d  = (state_q == IDLE)  ? (ld ? WRITE : IDLE)
             : (state_q == WRITE) ? ((bw_q == blk_t'(NUM_BLOCKS)) ? FIN : WRITE)
             : IDLE;
  end
  // state and registered dmem write port
  always_ff @(posedge clk)
    if (rst) begin
      state_q <= IDLE;
      off_q   <= '0;
      bw_q    <= '0;
      we_q    <= 1'b0;
      bd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      bidx_q  <= '0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      bw_q    <= bw_d;
      we_q    <= acc;
      bd_q    <= blk_end;
      if (acc) begin
        addr_q  <= {cur_blk, off_q};
        wdata_q <= bus.in_data;
        bidx_q  <= cur_blk;
      end
    end
  dmem_blk_ctr u_blk_ctr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (ld),
    .inc_i     (blk_end),
    .load_val_i(bus.start_block),
    .blk_o     (cur_blk)
  );
  assign bus.in_ready   = in_ready;
  assign bus.busy       = !rst && (state_q != IDLE);
  assign bus.frame_done = !rst && (state_q == FIN);
  assign bus.dmem_we    = we_q;
  assign bus.dmem_addr  = addr_q;
  assign bus.dmem_wdata = wdata_q;
  assign bus.block_done = bd_q;
  assign bus.blk_idx    = bidx_q;
endmodule

// File: tb/tb_dmem_wr_addr_gen.sv
// tb_dmem_wr_addr_gen: directed frames with per-write address/data/done checks
module tb_dmem_wr_addr_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_asrt = 0;
  int n_fail = 0;
  dmem_wr_addr_gen_if bus();
  dmem_wr_addr_gen dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one frame starting in an IDLE cycle (called #1 after an edge).
  task automatic run_frame(input logic [2:0] sb, input int stall_at, input bit busy_start,
                           output int first_a, output int last_a, output int last_b);
    int w = 0, s = 0, cyc = 0, gaps = 0, stall = 0, b0, blk;
    bit fin = 0;
    b0 = (sb == 3'd7) ? 0 : int'(sb);
    first_a = -1; last_a = -1; last_b = -1;
    bus.start = 1'b1; bus.start_block = sb; bus.in_valid = 1'b1; bus.in_data = 16'd0;
    chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);
    while (!fin && cyc < 400) begin
      tick();
      cyc++;
      bus.start = 1'b0;
      if (w == 112) begin
        chk("frame_done_pulse", {31'd0, bus.frame_done}, 32'd1);
        chk("fin_we", {31'd0, bus.dmem_we}, 32'd0);
        chk("fin_busy", {31'd0, bus.busy}, 32'd1);
        fin = 1;
        if (busy_start) begin bus.start = 1'b1; bus.start_block = 3'd4; end
      end else begin
        chk("frame_done_early", {31'd0, bus.frame_done}, 32'd0);
        if (bus.dmem_we) begin
          blk = (b0 + w / 16) % 7;
          if (first_a < 0) first_a = int'(bus.dmem_addr);
          last_a = int'(bus.dmem_addr);
          last_b = int'(bus.blk_idx);
          chk("addr", 32'(bus.dmem_addr), 32'(blk * 16 + w % 16));
          chk("wdata", 32'(bus.dmem_wdata), 32'(w));
          chk("blk_idx", 32'(bus.blk_idx), 32'(blk));
          chk("block_done", {31'd0, bus.block_done}, {31'd0, (w % 16) == 15});
          w++;
          if (w == 112) chk("ready_drop", {31'd0, bus.in_ready}, 32'd0);
        end else begin
          chk("block_done_idle", {31'd0, bus.block_done}, 32'd0);
          if (w > 0) gaps++;
        end
      end
      if (busy_start && s == 50 && !fin) begin bus.start = 1'b1; bus.start_block = 3'd3; end
      bus.in_valid = 1'b1;
      if (stall_at >= 0 && s == stall_at && stall < 2) begin bus.in_valid = 1'b0; stall++; end
      bus.in_data = 16'(s);
      if (bus.in_valid && bus.in_ready) s++;
    end
    if (!fin) chk("frame_timeout", 32'd0, 32'd1);
    chk("accepted_words", 32'(s), 32'd112);
    chk("gap_cycles", 32'(gaps), (stall_at >= 0) ? 32'd2 : 32'd0);
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    chk("post_busy", {31'd0, bus.busy}, 32'd0);
    chk("post_frame_done", {31'd0, bus.frame_done}, 32'd0);
  endtask

  initial begin
    int fa, la, lb, w;
    bus.start = 1'b1; bus.start_block = 3'd0; bus.in_valid = 1'b1; bus.in_data = 16'h1234;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_we", {31'd0, bus.dmem_we}, 32'd0);
      chk("rst_addr", 32'(bus.dmem_addr), 32'd0);
      chk("rst_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_bd", {31'd0, bus.block_done}, 32'd0);
      chk("rst_fd", {31'd0, bus.frame_done}, 32'd0);
    end
    rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
    tick();
    run_frame(3'd0, -1, 1'b0, fa, la, lb);
    chk("f0_first", 32'(fa), 32'd0);
    chk("f0_last", 32'(la), 32'd111);
    chk("f0_last_blk", 32'(lb), 32'd6);
    run_frame(3'd5, -1, 1'b0, fa, la, lb);
    chk("f5_first", 32'(fa), 32'd80);
    chk("f5_last", 32'(la), 32'd79);
    chk("f5_last_blk", 32'(lb), 32'd4);
    run_frame(3'd1, 5, 1'b0, fa, la, lb);
    chk("stall_first", 32'(fa), 32'd16);
    chk("stall_last", 32'(la), 32'd15);
    run_frame(3'd7, -1, 1'b1, fa, la, lb);
    chk("sb7_first", 32'(fa), 32'd0);
    chk("sb7_last", 32'(la), 32'd111);
    bus.start = 1'b1; bus.start_block = 3'd0; bus.in_valid = 1'b1; bus.in_data = 16'd0;
    w = 0;
    for (int c = 0; c < 100 && w < 40; c++) begin
      tick();
      bus.start = 1'b0;
      if (bus.dmem_we) w++;
    end
    chk("pre_rst_writes", 32'(w), 32'd40);
    rst = 1'b1;
    tick();
    chk("mid_rst_we", {31'd0, bus.dmem_we}, 32'd0);
    chk("mid_rst_addr", 32'(bus.dmem_addr), 32'd0);
    chk("mid_rst_wdata", 32'(bus.dmem_wdata), 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("mid_rst_bd", {31'd0, bus.block_done}, 32'd0);
    tick();
    rst = 1'b0; bus.in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("no_frame_done", {31'd0, bus.frame_done}, 32'd0);
      chk("no_write", {31'd0, bus.dmem_we}, 32'd0);
    end
    run_frame(3'd2, -1, 1'b0, fa, la, lb);
    chk("restart_first", 32'(fa), 32'd32);
    chk("restart_last", 32'(la), 32'd31);
    chk("restart_last_blk", 32'(lb), 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/dmem_wr_addr_gen.md
Name: dmem_wr_addr_gen

Overview:
Write-side address generator and controller for the 7-block x 16-word data memory (112 words, 7-bit address).
- Accepts a valid/ready stream of result words from the compute datapath.
- Writes each accepted word into dmem at address (block<<4)+offset.
- Fills whole blocks in order, starting at a programmable block and wrapping mod 7.
- Signals per-block and per-frame completion so the read-side sequencer can consume blocks.

Parameters:
NUM_BLOCKS, 7, number of 16-word blocks in dmem (block index 0..6)
BLOCK_WORDS, 16, words per block (offset is 4 bits)
ADDR_W, 7, dmem address width
DATA_W, 16, dmem word width

Ports:
clk  input  1  rising-edge clock, single clock domain
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a frame when idle
start_block  input  3  first block of the frame, sampled on accepted start; value 7 is treated as 0
in_valid  input  1  upstream word valid
in_data  input  DATA_W  upstream word
in_ready  output  1  block can accept a word this cycle
dmem_we  output  1  registered write enable
dmem_addr  output  ADDR_W  registered write address
dmem_wdata  output  DATA_W  registered write data
busy  output  1  frame in progress
block_done  output  1  one-cycle pulse coinciding with the write of offset 15 of any block
blk_idx  output  3  block index of the current dmem_we write (valid when dmem_we=1)
frame_done  output  1  one-cycle pulse the cycle after the 112th write

Behaviour:
- Reset: synchronous, active-high. On rst=1 at a clk edge, all outputs and state go to 0 and the FSM goes to IDLE; this applies mid-frame too, with no partial write and no done pulses. Outputs are held at 0 while rst is high.
- FSM states are IDLE, WRITE and FIN.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 moves the FSM to WRITE next cycle and loads cur_block=start_block (7 maps to 0), offset=0, blocks_written=0.
- WRITE:
  - in_ready=1, busy=1.
  - A word is accepted when in_valid & in_ready.
  - On acceptance, registered on the next edge: dmem_we=1, dmem_addr={cur_block,offset}, dmem_wdata=in_data, blk_idx=cur_block. Latency from accepted word to write is exactly 1 cycle.
  - If no word is accepted, dmem_we=0 next cycle and address/data hold their previous values.
  - offset increments on each acceptance and wraps 15->0.
  - At the offset-15 acceptance:
    - cur_block <= (cur_block==6) ? 0 : cur_block+1.
    - blocks_written increments.
    - block_done is registered high alongside that write.
  - The acceptance that completes block 7 of 7 moves the FSM to FIN; in_ready drops the following cycle, so exactly 112 words are accepted.
- FIN:
  - busy=1, in_ready=0.
  - frame_done=1 for one cycle, which is the cycle after the last dmem_we.
  - Next state is IDLE.
- start is ignored when not in IDLE, including a start in the same cycle as frame_done. A start in the first IDLE cycle after FIN is accepted.
- start and in_valid asserted in the same IDLE cycle: the start is taken and the word is not accepted (in_ready=0).
- Address arithmetic:
  - Block index is 3 bits and never reaches 7.
  - Address is a concatenation, not an addition, so there is no overflow.
  - Addresses 112..127 are never written.
- Ordering matches the read side's block-granular access: a block is complete in dmem when its block_done pulse has been seen.

Decomposition:
- Shared package dmem_pkg holds:
  - NUM_BLOCKS, BLOCK_WORDS, ADDR_W, DATA_W constants.
  - The block-index typedef (3 bits).
  - The FSM state enum.
  - A next_block_mod7 function, shared with the read-side generator.
- One natural sub-module: dmem_blk_ctr, a mod-7 block counter with load, increment and wrap.

Test Plan:
1. Reset check: assert rst for 3 cycles with in_valid=1 and start=1 -> dmem_we=0, dmem_addr=0, in_ready=0, busy=0, block_done=0, frame_done=0 throughout.
2. Continuous frame from block 0: start with start_block=0, in_valid=1 and in_data=index.
   - dmem_addr runs 0..111 on consecutive cycles, with wdata equal to address.
   - block_done fires at addresses 15, 31, ..., 111 (7 pulses).
   - frame_done fires one cycle after address 111; exactly 112 writes.
3. Wrap-around from block 5: start with start_block=5.
   - Block order is 5,6,0,1,2,3,4.
   - First address 80; address 111 is followed by 0; last address 79.
   - Last blk_idx=4.
4. Stalls: toggle in_valid 1,0,0,1 within a block -> no dmem_we in the cycles after the gaps; addresses stay contiguous; no duplicated or skipped offset.
5. Protocol edges:
   - start while busy is ignored; the frame still completes at 112 writes.
   - start_block=7 behaves as 0 (first address 0).
6. Reset mid-operation: rst=1 after 40 writes -> outputs return to 0 next cycle and no frame_done. A new start with start_block=2 restarts at address 32.
